// File: rtl/step_datapath_pkg.sv
// Shared opcodes and default sizes for the step datapath and its strobe decoder.
package step_datapath_pkg;
    localparam int WIDTH_DEF     = 8;
    localparam int CNT_WIDTH_DEF = 4;

    localparam logic [2:0] OP_NONE    = 3'd0;
    localparam logic [2:0] OP_S0      = 3'd1;
    localparam logic [2:0] OP_S1      = 3'd2;
    localparam logic [2:0] OP_S2      = 3'd3;
    localparam logic [2:0] OP_S3      = 3'd4;
    localparam logic [2:0] OP_S4      = 3'd5;
    localparam logic [2:0] OP_S5      = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;
endpackage

// File: rtl/step_datapath_strobe_decoder.sv
// Maps the six step strobes to one opcode; anything other than zero or one-hot is illegal.
module strobe_decoder
    import step_datapath_pkg::*;
(
    input  logic [5:0] i_strb,
    output logic [2:0] o_op
);
    always_comb begin
        o_op = OP_ILLEGAL;
        case (i_strb)
            6'b000000: o_op = OP_NONE;
            6'b000001: o_op = OP_S0;
            6'b000010: o_op = OP_S1;
            6'b000100: o_op = OP_S2;
            6'b001000: o_op = OP_S3;
            6'b010000: o_op = OP_S4;
            6'b100000: o_op = OP_S5;
            default:   o_op = OP_ILLEGAL;
        endcase
    end
endmodule

// File: rtl/step_datapath.sv
// Executes controller step strobes on operand, accumulator, counter and result registers;
// reports a sticky overflow back to the controller.
module step_datapath
    import step_datapath_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_clr,
    input  logic                 i_s0,
    input  logic                 i_s1,
    input  logic                 i_s2,
    input  logic                 i_s3,
    input  logic                 i_s4,
    input  logic                 i_s5,
    input  logic [WIDTH-1:0]     i_din,
    output logic [WIDTH-1:0]     o_dout,
    output logic                 o_overflow,
    output logic                 o_done,
    output logic                 o_err,
    output logic [CNT_WIDTH-1:0] o_cnt
);
    logic [WIDTH-1:0]     r_a, r_b, r_acc, r_dout;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_ovf, r_done, r_err;

    logic [2:0]           w_op;
    logic [WIDTH-1:0]     w_operand;
    logic [WIDTH:0]       w_sum;
    logic                 w_cnt_full;

    strobe_decoder u_dec (
        .i_strb ({i_s5, i_s4, i_s3, i_s2, i_s1, i_s0}),
        .o_op   (w_op)
    );

    assign w_operand  = (w_op == OP_S4) ? r_b : r_a;
    assign w_sum      = {1'b0, r_acc} + {1'b0, w_operand};
    assign w_cnt_full = &r_cnt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_dout <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else if (i_clr) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_dout <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (w_op)
                OP_S0: begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end
                OP_S1: r_a <= i_din;
                OP_S2: r_b <= i_din;
                OP_S3: if (!r_ovf) begin
                    r_acc <= w_sum[WIDTH-1:0];
                    // the count never wraps: it stays at all-ones on the attempt that trips overflow
                    if (!w_cnt_full) r_cnt <= r_cnt + 1'b1;
                    if (w_sum[WIDTH] || w_cnt_full) r_ovf <= 1'b1;
                end
                OP_S4: if (!r_ovf) begin
                    r_acc <= w_sum[WIDTH-1:0];
                    if (w_sum[WIDTH]) r_ovf <= 1'b1;
                end
                OP_S5: begin
                    r_dout <= r_acc;
                    r_done <= 1'b1;
                end
                OP_ILLEGAL: r_err <= 1'b1;
                default: ;
            endcase
        end
    end

    assign o_dout     = r_dout;
    assign o_overflow = r_ovf;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_cnt      = r_cnt;
endmodule

// File: tb/tb_step_datapath.sv
// Directed vector bench for step_datapath: async reset sequence, then a table of per-cycle vectors.
module tb_step_datapath;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [5:0] strb;
    logic [7:0] din;
    logic [7:0] dout;
    logic [3:0] cnt;
    logic       ovf, done, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    step_datapath #(.WIDTH(8), .CNT_WIDTH(4)) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_clr      (clr),
        .i_s0       (strb[0]),
        .i_s1       (strb[1]),
        .i_s2       (strb[2]),
        .i_s3       (strb[3]),
        .i_s4       (strb[4]),
        .i_s5       (strb[5]),
        .i_din      (din),
        .o_dout     (dout),
        .o_overflow (ovf),
        .o_done     (done),
        .o_err      (err),
        .o_cnt      (cnt)
    );

    typedef struct {
        logic       clr;
        logic [5:0] strb;
        logic [7:0] din;
        logic [7:0] dout;
        logic [3:0] cnt;
        logic       ovf;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vq[$];

    localparam logic [5:0] N  = 6'b000000;
    localparam logic [5:0] S0 = 6'b000001;
    localparam logic [5:0] S1 = 6'b000010;
    localparam logic [5:0] S2 = 6'b000100;
    localparam logic [5:0] S3 = 6'b001000;
    localparam logic [5:0] S4 = 6'b010000;
    localparam logic [5:0] S5 = 6'b100000;

    task automatic add(input logic c, input logic [5:0] s, input logic [7:0] d,
                       input logic [7:0] edout, input logic [3:0] ecnt,
                       input logic eovf, input logic edone, input logic eerr);
        vq.push_back('{c, s, d, edout, ecnt, eovf, edone, eerr});
    endtask

    task automatic check(input string name, input logic [14:0] exp);
        logic [14:0] act;
        act = {dout, cnt, ovf, done, err};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got dout=%h cnt=%0d ovf=%b done=%b err=%b, want dout=%h cnt=%0d ovf=%b done=%b err=%b",
                     name, act[14:7], act[6:3], act[2], act[1], act[0],
                     exp[14:7], exp[6:3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; strb = N; din = 8'h00;
        #12;
        check("reset_initial", 15'd0);
        @(negedge clk); rst_n = 1'b1;

        // build up state, then drop reset between edges
        @(negedge clk); strb = S1; din = 8'h07;
        @(negedge clk); strb = S0;
        @(negedge clk); strb = S3;
        @(negedge clk); strb = S5;
        @(negedge clk); strb = S3;
        #1;
        check("pre_reset", {8'h07, 4'd1, 1'b0, 1'b1, 1'b0});
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", 15'd0);
        strb = S5;
        @(posedge clk); #1;
        check("reset_held_edge1", 15'd0);
        strb = 6'b000110;
        @(posedge clk); #1;
        check("reset_held_edge2", 15'd0);
        @(negedge clk); strb = N; rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_release", 15'd0);

        // add(clr, strb, din, dout, cnt, ovf, done, err)
        add(0, S1, 8'h20, 8'h00, 0, 0, 0, 0);
        add(0, S2, 8'h05, 8'h00, 0, 0, 0, 0);
        add(0, S0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, S3, 8'h00, 8'h00, 1, 0, 0, 0);
        add(0, S4, 8'h00, 8'h00, 1, 0, 0, 0);
        add(0, S5, 8'h00, 8'h25, 1, 0, 1, 0);
        add(0, N,  8'h00, 8'h25, 1, 0, 0, 0);
        add(0, N,  8'h99, 8'h25, 1, 0, 0, 0);
        // carry overflow, then frozen ACC/CNT
        add(0, S1, 8'hF0, 8'h25, 1, 0, 0, 0);
        add(0, S0, 8'h00, 8'h25, 0, 0, 0, 0);
        add(0, S3, 8'h00, 8'h25, 1, 0, 0, 0);
        add(0, S3, 8'h00, 8'h25, 2, 1, 0, 0);
        add(0, S3, 8'h00, 8'h25, 2, 1, 0, 0);
        add(0, S4, 8'h00, 8'h25, 2, 1, 0, 0);
        add(0, S5, 8'h00, 8'hE0, 2, 1, 1, 0);
        add(0, S5, 8'h00, 8'hE0, 2, 1, 1, 0);
        add(0, S0, 8'h00, 8'hE0, 0, 1, 0, 0);
        add(0, S5, 8'h00, 8'h00, 0, 1, 1, 0);
        // counter saturation overflow
        add(1, N,  8'h00, 8'h00, 0, 0, 0, 0);
        add(0, S1, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, S0, 8'h00, 8'h00, 0, 0, 0, 0);
        for (int k = 1; k <= 15; k++) add(0, S3, 8'h00, 8'h00, 4'(k), 0, 0, 0);
        add(0, S3, 8'h00, 8'h00, 15, 1, 0, 0);
        add(0, S3, 8'h00, 8'h00, 15, 1, 0, 0);
        // illegal multi-hot strobe
        add(1, N,  8'h00, 8'h00, 0, 0, 0, 0);
        add(0, S1, 8'h11, 8'h00, 0, 0, 0, 0);
        add(0, S2, 8'h02, 8'h00, 0, 0, 0, 0);
        add(0, S1 | S2, 8'h33, 8'h00, 0, 0, 0, 1);
        add(0, S0, 8'h00, 8'h00, 0, 0, 0, 1);
        add(0, S3, 8'h00, 8'h00, 1, 0, 0, 1);
        add(0, S4, 8'h00, 8'h00, 1, 0, 0, 1);
        add(0, S5 | S3 | S0, 8'h00, 8'h00, 1, 0, 0, 1);
        add(0, S5, 8'h00, 8'h13, 1, 0, 1, 1);
        add(1, S5, 8'h00, 8'h00, 0, 0, 0, 0);
        // CLR beats a concurrent S3
        add(0, S1, 8'h01, 8'h00, 0, 0, 0, 0);
        add(0, S0, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, S3, 8'h00, 8'h00, 1, 0, 0, 0);
        add(0, S1, 8'h10, 8'h00, 1, 0, 0, 0);
        add(1, S3, 8'h00, 8'h00, 0, 0, 0, 0);
        add(0, S5, 8'h00, 8'h00, 0, 0, 1, 0);
        add(0, S3, 8'h00, 8'h00, 1, 0, 0, 0);
        add(0, S5, 8'h00, 8'h00, 1, 0, 1, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            clr = vq[i].clr; strb = vq[i].strb; din = vq[i].din;
            @(posedge clk); #1;
            check($sformatf("vec%0d", i),
                  {vq[i].dout, vq[i].cnt, vq[i].ovf, vq[i].done, vq[i].err});
        end

        @(negedge clk); clr = 1'b0; strb = N;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
